// File: rtl/sha1_padder.sv
// sha1_padder
//   Message pre-processing stage in front of the SHA-1 block. It collects a
//   big-endian 32-bit word stream into 512-bit blocks. It then applies the
//   SHA-1 padding: a 0x80 byte, zero fill, and the 64-bit big-endian message
//   bit length.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   in_data_i        message word, byte 0 in bits [31:24]
//   in_bytes_i       valid bytes in the word, MSB-aligned (0..4)
//   in_last_i        final word of the message
//   in_valid_i       input word valid
//   in_ready_o       input word accepted when valid && ready
//   block_o          padded block, word 0 in bits [511:480]
//   block_first_o    block is the first of a message
//   block_last_o     block is the last of a message (carries the length)
//   block_valid_o    block available
//   block_ready_i    consumer accepts the block
//   err_o            sticky protocol error
//
// Build option
//   SHA1_PADDER_ERR_EN  enables the err_o protocol checker. Without it,
//                       err_o is tied to 0.
module sha1_padder #(
  parameter int BlockWidth = 512,
  parameter int WordWidth  = 32,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WordWidth-1:0]  in_data_i,
  input  logic [2:0]            in_bytes_i,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_first_o,
  output logic                  block_last_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT_DATA  = 2'd1,
    EMIT_FINAL = 2'd2
  } state_t;

  state_t                state_q, state_nxt;
  logic [511:0]          buf_q, buf_nxt;
  logic [3:0]            w_q, w_nxt;
  logic [LenWidth-1:0]   len_q, len_nxt;
  logic                  first_q, first_nxt;
  logic                  pend_len_q, pend_len_nxt;
  logic                  pend_80_q, pend_80_nxt;

  logic                  acc;
  logic [2:0]            eff_bytes;
  logic                  eff_last;
  logic [31:0]           word;
  logic [6:0]            fill_cnt;
  logic [63:0]           len_field;

  // Keep only the first n bytes of a word and force the rest to zero.
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    mask_bytes = 32'h0;
      3'd1:    mask_bytes = {d[31:24], 24'h0};
      3'd2:    mask_bytes = {d[31:16], 16'h0};
      3'd3:    mask_bytes = {d[31:8], 8'h0};
      default: mask_bytes = d;
    endcase
  endfunction

`ifdef SHA1_PADDER_ERR_EN
  logic err_q, err_nxt;
  logic bad;
  // An offending word is taken as a full, non-last word.
  assign bad       = (in_bytes_i > 3'd4) || (!in_last_i && in_bytes_i != 3'd4);
  assign eff_bytes = bad ? 3'd4 : in_bytes_i;
  assign eff_last  = in_last_i && !bad;
  assign err_o     = err_q;
`else
  assign eff_bytes = (in_bytes_i > 3'd4 || !in_last_i) ? 3'd4 : in_bytes_i;
  assign eff_last  = in_last_i;
  assign err_o     = 1'b0;
`endif

  assign acc       = in_valid_i && (state_q == FILL);
  assign word      = mask_bytes(in_data_i, eff_bytes);
  assign fill_cnt  = {1'b0, w_q, 2'b00} + {4'b0, eff_bytes};
  assign len_field = 64'(len_nxt);

  assign in_ready_o    = (state_q == FILL);
  assign block_valid_o = (state_q != FILL);
  assign block_last_o  = (state_q == EMIT_FINAL);
  assign block_first_o = first_q;
  assign block_o       = buf_q;

  always_comb begin
    state_nxt    = state_q;
    buf_nxt      = buf_q;
    w_nxt        = w_q;
    len_nxt      = len_q;
    first_nxt    = first_q;
    pend_len_nxt = pend_len_q;
    pend_80_nxt  = pend_80_q;
`ifdef SHA1_PADDER_ERR_EN
    err_nxt      = err_q | (acc & bad);
`endif
    case (state_q)
      FILL: begin
        if (acc) begin
          for (int i = 0; i < 16; i++)
            if (w_q == i[3:0]) buf_nxt[511-32*i -: 32] = word;
          w_nxt   = w_q + 4'd1;
          len_nxt = len_q + LenWidth'({eff_bytes, 3'b000});
          if (eff_last) begin
            // fill_cnt is the byte count in the block after this word.
            if (fill_cnt <= 7'd63)
              for (int i = 0; i < 64; i++)
                if (fill_cnt[5:0] == i[5:0]) buf_nxt[511-8*i -: 8] = 8'h80;
            if (fill_cnt <= 7'd55) begin
              buf_nxt[63:0] = len_field;
              state_nxt     = EMIT_FINAL;
            end else begin
              // The length does not fit, so it goes into an extra block.
              // The 0x80 also moves there if this block is completely full.
              pend_len_nxt = 1'b1;
              pend_80_nxt  = (fill_cnt == 7'd64);
              state_nxt    = EMIT_DATA;
            end
          end else if (w_q == 4'd15) begin
            state_nxt = EMIT_DATA;
          end
        end
      end
      EMIT_DATA: begin
        if (block_ready_i) begin
          w_nxt     = 4'd0;
          first_nxt = 1'b0;
          buf_nxt   = '0;
          if (pend_len_q) begin
            if (pend_80_q) buf_nxt[511:504] = 8'h80;
            buf_nxt[63:0] = 64'(len_q);
            state_nxt     = EMIT_FINAL;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      EMIT_FINAL: begin
        if (block_ready_i) begin
          buf_nxt      = '0;
          w_nxt        = 4'd0;
          len_nxt      = '0;
          first_nxt    = 1'b1;
          pend_len_nxt = 1'b0;
          pend_80_nxt  = 1'b0;
          state_nxt    = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FILL;
    else       state_q <= state_nxt;
  end

  // The buffer is cleared on reset as well, because zero fill depends on it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q      <= '0;
      w_q        <= 4'd0;
      len_q      <= '0;
      first_q    <= 1'b1;
      pend_len_q <= 1'b0;
      pend_80_q  <= 1'b0;
    end else begin
      buf_q      <= buf_nxt;
      w_q        <= w_nxt;
      len_q      <= len_nxt;
      first_q    <= first_nxt;
      pend_len_q <= pend_len_nxt;
      pend_80_q  <= pend_80_nxt;
    end
  end

`ifdef SHA1_PADDER_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_sha1_padder.sv
module tb_sha1_padder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  in_data_i = '0;
  logic [2:0]   in_bytes_i = '0;
  logic         in_last_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [511:0] block_o;
  logic         block_first_o;
  logic         block_last_o;
  logic         block_valid_o;
  logic         block_ready_i = 1'b0;
  logic         err_o;

  int n_cmp = 0;
  int n_bad = 0;

  sha1_padder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_data_i     (in_data_i),
    .in_bytes_i    (in_bytes_i),
    .in_last_i     (in_last_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .block_o       (block_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic last);
    int cnt = 0;
    in_data_i  = d;
    in_bytes_i = n;
    in_last_i  = last;
    in_valid_i = 1'b1;
    while (!in_ready_o && cnt < 100) begin
      @(negedge clk_i);
      cnt++;
    end
    if (!in_ready_o) chk("send_timeout", in_ready_o, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic get_block(input string tag, input logic [511:0] eb, input logic ef, input logic el);
    int cnt = 0;
    while (!block_valid_o && cnt < 50) begin
      @(negedge clk_i);
      cnt++;
    end
    chk({tag, "_valid"}, block_valid_o, 1);
    chk({tag, "_block"}, block_o, eb);
    chk({tag, "_first"}, block_first_o, ef);
    chk({tag, "_last"}, block_last_o, el);
    block_ready_i = 1'b1;
    @(negedge clk_i);
    block_ready_i = 1'b0;
  endtask

  task automatic send_a(input int nbytes);
    for (int i = 0; i < nbytes / 4; i++)
      send_word(32'h61616161, 3'd4, (i == nbytes / 4 - 1) && (nbytes % 4 == 0));
    if (nbytes % 4 != 0) send_word(32'h61616161, 3'(nbytes % 4), 1'b1);
  endtask

  function automatic logic [511:0] a_words(input int n);
    logic [511:0] b = '0;
    for (int i = 0; i < n; i++) b[511-32*i -: 32] = 32'h61616161;
    return b;
  endfunction

  function automatic logic [511:0] abc_blk();
    logic [511:0] b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    return b;
  endfunction

  task automatic pulse_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_valid", block_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_block", block_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [511:0] exp_b;
  logic [511:0] held;

  initial begin
    repeat (2) @(negedge clk_i);
    chk("reset_ready", in_ready_o, 1);
    chk("reset_valid", block_valid_o, 0);
    chk("reset_first", block_first_o, 1);
    chk("reset_last", block_last_o, 0);
    chk("reset_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // "abc"
    send_word(32'h61626300, 3'd3, 1'b1);
    chk("abc_latency", block_valid_o, 1);
    get_block("abc", abc_blk(), 1, 1);

    // Empty message, with garbage in the data bits
    send_word(32'hFFFFFFFF, 3'd0, 1'b1);
    exp_b = '0;
    exp_b[511:480] = 32'h80000000;
    get_block("empty", exp_b, 1, 1);

    // 55 bytes: 0x80 and the length both fit in a single block
    send_a(55);
    chk("a55_latency", block_valid_o, 1);
    exp_b = a_words(13);
    exp_b[511-32*13 -: 32] = 32'h61616180;
    exp_b[31:0] = 32'h000001B8;
    get_block("a55", exp_b, 1, 1);

    // 56 bytes: the length spills into a second block
    send_a(56);
    exp_b = a_words(14);
    exp_b[511-32*14 -: 32] = 32'h80000000;
    get_block("a56_b0", exp_b, 1, 0);
    chk("a56_b1_latency", block_valid_o, 1);
    exp_b = '0;
    exp_b[31:0] = 32'h000001C0;
    get_block("a56_b1", exp_b, 0, 1);

    // 64 bytes: the 0x80 and the length both go to the second block
    send_a(64);
    get_block("a64_b0", a_words(16), 1, 0);
    exp_b = '0;
    exp_b[511:480] = 32'h80000000;
    exp_b[31:0] = 32'h00000200;
    get_block("a64_b1", exp_b, 0, 1);
    // An immediate "abc" with a garbage low byte
    send_word(32'h616263FF, 3'd3, 1'b1);
    get_block("abc2", abc_blk(), 1, 1);

    // Backpressure, with the next message word waiting
    send_word(32'h61626300, 3'd3, 1'b1);
    held = block_o;
    chk("bp_initial", held, abc_blk());
    in_data_i  = 32'h61626300;
    in_bytes_i = 3'd3;
    in_last_i  = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_stable", block_o, held);
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_valid", block_valid_o, 1);
    end
    block_ready_i = 1'b1;
    @(negedge clk_i);
    block_ready_i = 1'b0;
    chk("bp_released", in_ready_o, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    get_block("bp_held_word", abc_blk(), 1, 1);

    // Reset in the middle of filling, with 7 words accepted
    for (int i = 0; i < 7; i++) send_word(32'h11111111, 3'd4, 1'b0);
    pulse_reset();
    chk("midrst_first", block_first_o, 1);
    send_word(32'h61626300, 3'd3, 1'b1);
    get_block("after_rst", abc_blk(), 1, 1);

    // Bad byte count on a non-last word
    send_word(32'hDEADBEEF, 3'd5, 1'b0);
`ifdef SHA1_PADDER_ERR_EN
    chk("err_set", err_o, 1);
    repeat (3) @(negedge clk_i);
    chk("err_sticky", err_o, 1);
`else
    chk("err_tied", err_o, 0);
`endif
    pulse_reset();
    chk("err_cleared", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Message pre-processing stage directly upstream of the SHA-1 block.
- Accepts a big-endian 32-bit word stream and assembles 512-bit blocks.
- Applies FIPS 180-4 padding: 0x80 byte, zero fill, then 64-bit big-endian message bit length.
- Presents each block with a valid/ready handshake and first/last markers, used to reset the hash and to detect when the digest is final.

Parameters:
- BlockWidth, 512, output block width; only 512 supported.
- WordWidth, 32, input word width; only 32 supported.
- LenWidth, 64, message bit-length counter width; appended field is always 64 bits, zero-extended.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_data_i  in  32  message word, byte 0 in bits [31:24]
- in_bytes_i  in  3  valid bytes in word, MSB-aligned; 4 unless in_last_i; 0 allowed only with in_last_i
- in_last_i  in  1  final word of message
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when valid && ready
- block_o  out  512  padded block, word 0 in bits [511:480]
- block_first_o  out  1  block is first of a message
- block_last_o  out  1  block is last of a message (contains length)
- block_valid_o  out  1  block available
- block_ready_i  in  1  consumer accepts block
- err_o  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset (async, rst_i=1): state FILL, word index 0, buffer 0, bit length 0, first flag 1. Outputs in_ready_o=1, block_valid_o=0, block_first_o=1, block_last_o=0, err_o=0. Reset mid-operation discards any partial block and pending output.
- State FILL:
  - in_ready_o=1. Each accepted word is written at word index w, and w increments.
  - Bit length increases by 8*in_bytes_i, wrapping mod 2^LenWidth.
  - Unused low bytes of a partial word are forced to 0.
- Non-last word with w=15 -> EMIT_DATA.
- Last word, with b = total bytes in the block after the word (0..64):
  - Case A, b<=55: write 0x80 at byte b, length into bytes 56..63 -> EMIT_FINAL.
  - Case B, 56<=b<=63: write 0x80 at byte b -> EMIT_DATA, pending_len=1, pending_80=0.
  - Case C, b=64: -> EMIT_DATA, pending_len=1, pending_80=1.
  - The length used is the updated value, including the current word.
- Buffer is cleared to 0 when a block is handed off, so zero fill is implicit.
- EMIT_DATA:
  - in_ready_o=0, block_valid_o=1, block_last_o=0.
  - On handshake: clear buffer, w=0, first flag=0.
  - If pending_len: build the extra block (0x80 at byte 0 if pending_80, length at bytes 56..63) and go to EMIT_FINAL; otherwise go to FILL.
- EMIT_FINAL:
  - block_valid_o=1, block_last_o=1.
  - On handshake: clear buffer, length=0, first flag=1, pending flags=0, -> FILL.
- block_first_o reflects the first flag and is valid while block_valid_o=1.
- block_o, block_first_o and block_last_o are held stable while block_valid_o=1 and block_ready_i=0.
- Latency: block_valid_o asserts the cycle after the accepting handshake of the completing word. A Case B/C extra block asserts the cycle after the first block's handshake.
- No input is accepted while a block is pending; single buffer only. Peak throughput is 1 block per 17 cycles.
- Empty message: in_last_i=1, in_bytes_i=0 at w=0 gives Case A with b=0.
- in_data_i bytes beyond in_bytes_i are ignored.

Optional Feature:
- Macro: SHA1_PADDER_ERR_EN.
- Defined: err_o sets, sticky until reset, on an accepted word with any of:
  - in_bytes_i>4;
  - in_bytes_i=0 with in_last_i=0;
  - in_bytes_i<4 with in_last_i=0.
  - The offending word is treated as in_bytes_i=4, not last.
- Not defined: err_o tied 0. Out-of-range in_bytes_i is treated as 4; non-last partial words are treated as 4 bytes.

Test Plan:
- "abc": one word 0x61626300, bytes=3, last -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, first=1, last=1.
- Empty message: bytes=0, last -> one block, word0=0x80000000, remainder 0, length 0, first=1, last=1.
- 55 bytes (0x61 repeated) -> one block, byte55=0x80, word15=0x000001B8. 56 bytes -> two blocks: first has byte56=0x80, last=0; second is all zero except word15=0x000001C0, last=1.
- 64 bytes -> two blocks; second word0=0x80000000, word15=0x00000200, first=0, last=1. Then an immediate second "abc" message -> first=1, length 0x18.
- Backpressure: hold block_ready_i=0 for 10 cycles -> block_o stable, in_ready_o=0, no words lost. Assert rst_i mid-fill at w=7 -> block_valid_o=0 and next message pads from w=0.
- With SHA1_PADDER_ERR_EN: word with bytes=5, last=0 -> err_o=1 next cycle, stays 1 until rst_i.
